// File: rtl/ca_code_nco.sv
// Phase-accumulator NCO producing C/A code chip/half-chip enables, chip index and epoch strobe.
// Optional snapshot capture is enabled by defining NCO_SNAPSHOT_EN.
module ca_code_nco #(
  parameter int unsigned            ACC_W           = 32,
  parameter int unsigned            CHIP_W          = 10,
  parameter int unsigned            CHIPS_PER_EPOCH = 1023,
  parameter logic [ACC_W-1:0]       FCW_RESET       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ACC_W-1:0]  fcw_in,
  input  logic              fcw_load,
  input  logic              phase_set,
  input  logic [ACC_W-1:0]  phase_in,
  input  logic [CHIP_W-1:0] chip_in,
  input  logic              snap_req,
  output logic              chip_tick,
  output logic              half_tick,
  output logic              epoch,
  output logic [CHIP_W-1:0] chip_cnt,
  output logic              fout,
  output logic [ACC_W-1:0]  snap_acc,
  output logic [CHIP_W-1:0] snap_chip,
  output logic              snap_valid
);

  localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(CHIPS_PER_EPOCH - 1);

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_fcw;
  logic [CHIP_W-1:0] r_chip;
  logic              r_chip_tick;
  logic              r_half_tick;
  logic              r_epoch;
  logic              r_fout;

  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic              w_last;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_fcw};
  assign w_carry = w_sum[ACC_W];
  assign w_last  = (r_chip == LAST_CHIP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_fcw       <= FCW_RESET;
      r_chip      <= '0;
      r_chip_tick <= 1'b0;
      r_half_tick <= 1'b0;
      r_epoch     <= 1'b0;
      r_fout      <= 1'b0;
    end else begin
      if (fcw_load) r_fcw <= fcw_in;
      r_chip_tick <= 1'b0;
      r_half_tick <= 1'b0;
      r_epoch     <= 1'b0;
      if (phase_set) begin
        r_acc  <= phase_in;
        r_chip <= chip_in;
        r_fout <= phase_in[ACC_W-1];
      end else if (en) begin
        // Add uses the pre-load fcw; a new word takes effect from the next edge.
        r_acc       <= w_sum[ACC_W-1:0];
        r_chip_tick <= w_carry;
        r_half_tick <= (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
        r_fout      <= w_sum[ACC_W-1];
        r_epoch     <= w_carry && w_last;
        if (w_carry) r_chip <= w_last ? '0 : r_chip + 1'b1;
      end
    end
  end

  assign chip_tick = r_chip_tick;
  assign half_tick = r_half_tick;
  assign epoch     = r_epoch;
  assign chip_cnt  = r_chip;
  assign fout      = r_fout;

`ifdef NCO_SNAPSHOT_EN
  logic [ACC_W-1:0]  r_snap_acc;
  logic [CHIP_W-1:0] r_snap_chip;
  logic              r_snap_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_acc   <= '0;
      r_snap_chip  <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= snap_req;
      if (snap_req) begin
        r_snap_acc  <= r_acc;
        r_snap_chip <= r_chip;
      end
    end
  end

  assign snap_acc   = r_snap_acc;
  assign snap_chip  = r_snap_chip;
  assign snap_valid = r_snap_valid;
`else
  logic w_unused_snap;
  assign w_unused_snap = snap_req;
  assign snap_acc      = '0;
  assign snap_chip     = '0;
  assign snap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ca_code_nco.sv
// Directed self-checking bench for ca_code_nco (ACC_W=8, CHIP_W=4, 5 chips/epoch, FCW_RESET=64).
module tb_ca_code_nco;

  logic       clk = 1'b0;
  logic       rst, en, fcw_load, phase_set, snap_req;
  logic [7:0] fcw_in, phase_in;
  logic [3:0] chip_in;
  logic       chip_tick, half_tick, epoch, fout, snap_valid;
  logic [3:0] chip_cnt, snap_chip;
  logic [7:0] snap_acc;

  int checks   = 0;
  int failures = 0;

  ca_code_nco #(
    .ACC_W(8), .CHIP_W(4), .CHIPS_PER_EPOCH(5), .FCW_RESET(8'd64)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fcw_in(fcw_in), .fcw_load(fcw_load),
    .phase_set(phase_set), .phase_in(phase_in), .chip_in(chip_in),
    .snap_req(snap_req), .chip_tick(chip_tick), .half_tick(half_tick),
    .epoch(epoch), .chip_cnt(chip_cnt), .fout(fout), .snap_acc(snap_acc),
    .snap_chip(snap_chip), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int acc, input int chip,
                           input int ct, input int ht, input int ep, input int fo);
    chk({tag, "_acc"},   32'(dut.r_acc), 32'(acc));
    chk({tag, "_chip"},  32'(chip_cnt),  32'(chip));
    chk({tag, "_ctick"}, 32'(chip_tick), 32'(ct));
    chk({tag, "_htick"}, 32'(half_tick), 32'(ht));
    chk({tag, "_epoch"}, 32'(epoch),     32'(ep));
    chk({tag, "_fout"},  32'(fout),      32'(fo));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fcw_load = 1'b0; phase_set = 1'b0; snap_req = 1'b0;
    fcw_in = '0; phase_in = '0; chip_in = '0;
    step(); step();
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_snapv", 32'(snap_valid), 0);
    chk("reset_snapa", 32'(snap_acc), 0);

    // basic rate at FCW_RESET = 64
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_state("rate", (64 * k) % 256, k / 4, int'(k % 4 == 0), int'(k % 2 == 0),
                0, int'((64 * k) % 256 >= 128));
    end

    // epoch wrap at FCW=128, starting from acc=0, chip=0
    phase_set = 1'b1; phase_in = 8'h00; chip_in = 4'd0; fcw_load = 1'b1; fcw_in = 8'd128;
    step();
    phase_set = 1'b0; fcw_load = 1'b0;
    chk_state("eps", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_state("epoch", (128 * k) % 256, (k / 2) % 5, int'(k % 2 == 0), 1,
                int'(k % 2 == 0 && (k / 2) % 5 == 0), int'(k % 2 == 1));
    end

    // FCW update: 64 for two edges, then load 32
    phase_set = 1'b1; phase_in = 8'h00; chip_in = 4'd0; fcw_load = 1'b1; fcw_in = 8'd64;
    step();
    phase_set = 1'b0; fcw_load = 1'b0;
    step(); step();
    chk("upd_pre_acc", 32'(dut.r_acc), 128);
    fcw_load = 1'b1; fcw_in = 8'd32;
    step();
    fcw_load = 1'b0;
    chk_state("upd_load", 192, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_state("upd", (192 + 32 * k) % 256, int'(k >= 2) + int'(k >= 10),
                int'(k == 2 || k == 10), int'(k == 2 || k == 6 || k == 10 || k == 14),
                0, int'((192 + 32 * k) % 256 >= 128));
    end

    // phase set mid-chip with en=1 at FCW=64 (load edge still adds 32)
    fcw_load = 1'b1; fcw_in = 8'd64;
    step();
    fcw_load = 1'b0;
    chk_state("ps_pre", 224, 2, 0, 0, 0, 1);
    phase_set = 1'b1; phase_in = 8'hF0; chip_in = 4'd3;
    step();
    phase_set = 1'b0;
    chk_state("ps_load", 8'hF0, 3, 0, 0, 0, 1);
    step();
    chk_state("ps_next", 8'h30, 4, 1, 1, 0, 0);

    // hold with en=0, fcw_load honoured while holding
    en = 1'b0; phase_set = 1'b1; phase_in = 8'hA0; chip_in = 4'd3;
    step();
    phase_set = 1'b0; fcw_load = 1'b1; fcw_in = 8'd16;
    for (int k = 1; k <= 5; k++) begin
      step();
      fcw_load = 1'b0;
      chk_state("hold", 8'hA0, 3, 0, 0, 0, 1);
    end
    en = 1'b1;
    step();
    chk_state("hold_fcw", 8'hB0, 3, 0, 0, 0, 1);

    // mid-chip reset, then FCW must be back at 64
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_state("rst_mid", 0, 0, 0, 0, 0, 0);
    step();
    chk_state("rst_fcw", 64, 0, 0, 0, 0, 0);

    // snapshot at acc=128, chip=2 while accumulating
    phase_set = 1'b1; phase_in = 8'h80; chip_in = 4'd2;
    step();
    phase_set = 1'b0; snap_req = 1'b1;
    step();
    snap_req = 1'b0; en = 1'b0;
    chk("snap_acc_now", 32'(dut.r_acc), 8'hC0);
`ifdef NCO_SNAPSHOT_EN
    chk("snap_valid", 32'(snap_valid), 1);
    chk("snap_acc", 32'(snap_acc), 128);
    chk("snap_chip", 32'(snap_chip), 2);
`else
    chk("snap_valid", 32'(snap_valid), 0);
    chk("snap_acc", 32'(snap_acc), 0);
    chk("snap_chip", 32'(snap_chip), 0);
`endif
    step();
    chk("snap_pulse_end", 32'(snap_valid), 0);

    // FCW = 0 freezes the accumulator
    fcw_load = 1'b1; fcw_in = 8'd0;
    step();
    fcw_load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_state("fcw0", 8'hC0, 2, 0, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
